// File: rtl/t05_sram_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, default timeout, channel indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t enum, DEF_TIMEOUT, IDX_W/SEL_W widths, channel index constants, wrap_inc helper.
package t05_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } state_t;

  localparam int DEF_TIMEOUT = 255;
  localparam int IDX_W       = 3;
  localparam int SEL_W       = 4;

  // Client channel indices
  localparam logic [IDX_W-1:0] CH_HIST  = 3'd0;
  localparam logic [IDX_W-1:0] CH_FLV   = 3'd1;
  localparam logic [IDX_W-1:0] CH_HTREE = 3'd2;
  localparam logic [IDX_W-1:0] CH_CB    = 3'd3;
  localparam logic [IDX_W-1:0] CH_TRN   = 3'd4;
  localparam logic [IDX_W-1:0] CH_SPI   = 3'd5;

  // Increment a channel index modulo n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    wrap_inc = (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/t05_rr_picker.sv
// Combinational grant picker: first set request at or after a start index (or lowest index).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; o_vld simply reflects whether any request is set.
// Ports: i_req request vector, i_start search origin, i_mode 1=rotate from i_start / 0=from 0,
//        o_idx winning channel, o_vld a winner exists.
module t05_rr_picker
  import t05_sram_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_start,
  input  logic              i_mode,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_vld
);

  logic [IDX_W-1:0] w_base;
  logic [IDX_W:0]   w_pos;

  always_comb begin
    w_base = i_mode ? i_start : '0;
    w_pos  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_pos = {1'b0, w_base} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_CH)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_CH);
      end
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// Arbitrates NUM_CH clients onto one wishbone-manager command port, one transaction at a time.
// Latency: request to ch_done is 5 cycles minimum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, COMPLETE).
// Backpressure: clients hold ch_req until ch_done; manager paces via busy_i; each wait phase times out.
// Ports: clk/rst; ch_req/ch_we/ch_addr/ch_wdata/ch_sel client side; ch_gnt/ch_done/ch_err/rdata_o
//        client responses; write_o/read_o/addr_o/wdata_o/sel_o/rdata_i/busy_i manager side; active_ch.
module t05_sram_arbiter
  import t05_sram_pkg::*;
#(
  parameter int NUM_CH  = 6,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH-1:0]         ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]  ch_wdata,
  input  logic [NUM_CH*SEL_W-1:0]   ch_sel,
  output logic [NUM_CH-1:0]         ch_gnt,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_err,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      write_o,
  output logic                      read_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic [SEL_W-1:0]          sel_o,
  input  logic [DATA_W-1:0]         rdata_i,
  input  logic                      busy_i,
  output logic [IDX_W-1:0]          active_ch
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic               w_tmo_hit;
  logic               w_tmo_fire;
  logic               r_we;
  logic               r_err;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [NUM_CH-1:0]  w_gnt_oh;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_rdata;

  assign w_start   = wrap_inc(r_last, NUM_CH);
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
  assign w_gnt_oh  = NUM_CH'(1) << r_gnt_idx;
  assign addr_o    = r_addr;
  assign wdata_o   = r_wdata;
  assign sel_o     = r_sel;
  assign rdata_o   = r_rdata;

  t05_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .i_req   (ch_req),
    .i_start (w_start),
    .i_mode  (RR_MODE != 0),
    .o_idx   (w_pick_idx),
    .o_vld   (w_pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_tmo_fire   = 1'b0;
    ch_gnt       = '0;
    ch_done      = '0;
    ch_err       = '0;
    write_o      = 1'b0;
    read_o       = 1'b0;
    active_ch    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        write_o      = r_we;
        read_o       = !r_we;
        w_next_state = ST_WAIT_ACK;
      end
      // A manager response in the last allowed cycle takes priority over the timeout.
      ST_WAIT_ACK: begin
        if (busy_i) begin
          w_next_state = ST_WAIT_DONE;
        end else if (w_tmo_hit) begin
          w_next_state = ST_COMPLETE;
          w_tmo_fire   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_i) begin
          w_next_state = ST_COMPLETE;
        end else if (w_tmo_hit) begin
          w_next_state = ST_COMPLETE;
          w_tmo_fire   = 1'b1;
        end
      end
      ST_COMPLETE: begin
        ch_done      = w_gnt_oh;
        ch_err       = r_err ? w_gnt_oh : '0;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (r_state != ST_IDLE) begin
      ch_gnt    = w_gnt_oh;
      active_ch = r_gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_idx <= '0;
      r_last    <= IDX_W'(NUM_CH - 1);
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      // Command fields are captured on the grant edge so they are valid during ISSUE
      // and stay put until the next grant.
      if (r_state == ST_IDLE && w_pick_vld) begin
        r_gnt_idx <= w_pick_idx;
        r_we      <= ch_we[w_pick_idx];
        r_addr    <= ch_addr[w_pick_idx*ADDR_W +: ADDR_W];
        r_wdata   <= ch_wdata[w_pick_idx*DATA_W +: DATA_W];
        r_sel     <= ch_sel[w_pick_idx*SEL_W +: SEL_W];
      end
      if (r_state == ST_WAIT_DONE && !busy_i && !r_we) begin
        r_rdata <= rdata_i;
      end
      if (r_state == ST_COMPLETE) begin
        r_last <= r_gnt_idx;
      end
      r_err <= w_tmo_fire;
      // Counter runs only while staying in a wait state, so it restarts at 0 on every entry.
      if ((r_state == ST_WAIT_ACK || r_state == ST_WAIT_DONE) && w_next_state == r_state) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
module tb_t05_sram_arbiter;

  localparam int N   = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     ch_req, ch_we;
  logic [N*AW-1:0]  ch_addr;
  logic [N*DW-1:0]  ch_wdata;
  logic [N*4-1:0]   ch_sel;
  logic [DW-1:0]    rdata_i;
  logic             busy_i;

  logic [N-1:0]     ch_gnt, ch_done, ch_err;
  logic [DW-1:0]    rdata_o, wdata_o;
  logic [AW-1:0]    addr_o;
  logic [3:0]       sel_o;
  logic             write_o, read_o;
  logic [2:0]       active_ch;

  logic [N-1:0]     fx_gnt, fx_done, fx_err;
  logic [DW-1:0]    fx_rdata, fx_wdata;
  logic [AW-1:0]    fx_addr;
  logic [3:0]       fx_sel;
  logic             fx_write, fx_read;
  logic [2:0]       fx_act;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               m_last;
  logic [DW-1:0]    m_rdata;

  always #5 clk = ~clk;

  t05_sram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .RR_MODE(1)) u_dut_rr (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_sel(ch_sel), .ch_gnt(ch_gnt), .ch_done(ch_done),
    .ch_err(ch_err), .rdata_o(rdata_o), .write_o(write_o), .read_o(read_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .sel_o(sel_o), .rdata_i(rdata_i),
    .busy_i(busy_i), .active_ch(active_ch)
  );

  t05_sram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .RR_MODE(0)) u_dut_fx (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_sel(ch_sel), .ch_gnt(fx_gnt), .ch_done(fx_done),
    .ch_err(fx_err), .rdata_o(fx_rdata), .write_o(fx_write), .read_o(fx_read),
    .addr_o(fx_addr), .wdata_o(fx_wdata), .sel_o(fx_sel), .rdata_i(rdata_i),
    .busy_i(busy_i), .active_ch(fx_act)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan from the channel after the last grant, wrapping around.
  function automatic int pick_rr(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  function automatic int pick_fx(input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      if (req[i]) return i;
    end
    return 0;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      ch_addr[i*AW +: AW]  = $urandom;
      ch_wdata[i*DW +: DW] = $urandom;
      ch_sel[i*4 +: 4]     = 4'($urandom);
    end
  endtask

  // One transaction. Request applied in cycle 0; busy rises in cycle 2+a and stays high b cycles
  // (a >= TMO means it never rises). Expected completion cycle follows from the wait/timeout rules.
  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] we, input int a,
                         input int b, input bit drop, input logic [DW-1:0] rdv);
    int          g, gf, done_n;
    bit          terr;
    logic [63:0] oh, ohf;
    logic [1:0]  strobe;
    @(negedge clk);
    busy_i = 1'b0;
    chk("idle_gnt", ch_gnt, 0);
    chk("idle_act", active_ch, 0);
    ch_req = req;
    ch_we  = we;
    g  = pick_rr(req, m_last);
    gf = pick_fx(req);
    if (a >= TMO) begin
      done_n = 2 + TMO;     terr = 1'b1;
    end else if (b > TMO) begin
      done_n = 3 + a + TMO; terr = 1'b1;
    end else begin
      done_n = 3 + a + b;   terr = 1'b0;
    end
    oh     = 64'd1 << g;
    ohf    = 64'd1 << gf;
    strobe = we[g] ? 2'b10 : 2'b01;
    if (!terr && !we[g]) m_rdata = rdv;
    for (int n = 1; n <= done_n; n++) begin
      @(negedge clk);
      busy_i  = (a < TMO) && (n >= 2 + a) && (n < 2 + a + b);
      rdata_i = (n == 2 + a + b) ? rdv : $urandom;
      if (drop && n == 2) ch_req[g] = 1'b0;
      chk("strobe", {write_o, read_o}, (n == 1) ? strobe : 2'b00);
      chk("done", ch_done, (n == done_n) ? oh : 64'd0);
      chk("gnt", ch_gnt, oh);
      if (n == 1) begin
        chk("active_ch", active_ch, g);
        chk("addr_o", addr_o, ch_addr[g*AW +: AW]);
        chk("wdata_o", wdata_o, ch_wdata[g*DW +: DW]);
        chk("sel_o", sel_o, ch_sel[g*4 +: 4]);
        chk("fx_gnt", fx_gnt, ohf);
      end
      if (n == done_n) begin
        chk("err", ch_err, terr ? oh : 64'd0);
        chk("rdata_o", rdata_o, m_rdata);
        chk("addr_hold", addr_o, ch_addr[g*AW +: AW]);
        chk("fx_done", fx_done, ohf);
        chk("fx_err", fx_err, terr ? ohf : 64'd0);
      end
    end
    m_last = g;
  endtask

  initial begin
    logic [N-1:0] rq;
    int           gp;
    rst     = 1'b1;
    ch_req  = '0;
    ch_we   = '0;
    busy_i  = 1'b0;
    rdata_i = '0;
    rand_fields();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {ch_gnt, ch_done, ch_err, write_o, read_o, active_ch}, 0);
    chk("rst_dat", {addr_o, wdata_o}, 0);
    chk("rst_rd", {rdata_o, sel_o}, 0);
    rst     = 1'b0;
    m_last  = N - 1;
    m_rdata = '0;

    // Single read on channel 2 with a 2-cycle busy pulse.
    rand_fields();
    ch_addr[2*AW +: AW] = 32'h40;
    run_txn(6'b000100, 6'b000000, 0, 2, 1'b0, 32'hDEADBEEF);
    // Minimum-turnaround write on channel 0.
    rand_fields();
    run_txn(6'b000001, 6'b000001, 0, 1, 1'b0, $urandom);

    // Reset while in WAIT_DONE aborts with no done pulse.
    rand_fields();
    @(negedge clk);
    rq     = 6'b011000;
    gp     = pick_rr(rq, m_last);
    ch_req = rq;
    ch_we  = '0;
    @(negedge clk);
    @(negedge clk);
    busy_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_gnt", ch_gnt, 64'd1 << gp);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {ch_gnt, ch_done, ch_err, write_o, read_o, active_ch}, 0);
    chk("mid_rst_dat", {addr_o, wdata_o}, 0);
    chk("mid_rst_rd", {rdata_o, sel_o}, 0);
    rst     = 1'b0;
    busy_i  = 1'b0;
    ch_req  = '0;
    m_last  = N - 1;
    m_rdata = '0;

    // Round-robin fairness with every channel requesting: channel 0 first after reset.
    for (int t = 0; t < 2 * N; t++) begin
      rand_fields();
      run_txn(6'b111111, 6'($urandom), 0, 1, 1'b0, $urandom);
    end

    // 3 and 5 requesting: fixed-priority instance must keep choosing 3.
    for (int t = 0; t < 4; t++) begin
      rand_fields();
      run_txn(6'b101000, 6'($urandom), $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, $urandom);
    end

    // WAIT_ACK timeout on a write from channel 1, then a WAIT_DONE timeout on a read.
    rand_fields();
    run_txn(6'b000010, 6'b000010, 100, 0, 1'b0, $urandom);
    rand_fields();
    run_txn(6'b000010, 6'b000000, 1, 12, 1'b0, $urandom);

    // Channel 4 drops its request mid-transaction; still completes, no regrant to 4.
    rand_fields();
    run_txn(6'b010000, 6'b000000, 1, 2, 1'b1, $urandom);
    rand_fields();
    run_txn(6'b000011, 6'b000000, 0, 1, 1'b0, $urandom);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      rand_fields();
      run_txn(6'($urandom_range(1, 63)), 6'($urandom), $urandom_range(0, 9),
              $urandom_range(1, 10), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
